// File: rtl/gcd_sched_pkg.sv
// Shared definitions for the round-robin GCD scheduler.
//   state_t     : scheduler FSM states
//   DEF_W       : default operand/result width
//   DEF_TIMEOUT : default watchdog limit in WAIT cycles
//   id_width()  : bits needed to encode a requester index (at least 1)
package gcd_sched_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 70000;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_rr_scheduler_arb.sv
// Round-robin arbiter: combinational, stateless.
//   valid : per-requester request valid
//   ptr   : highest-priority index this cycle (0..N-1)
//   grant : one-hot grant, zero when nothing is valid
//   idx   : encoded index of the granted requester
//   any   : at least one requester is valid
module rr_arbiter
  import gcd_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // One extra bit so ptr+off cannot overflow before the explicit wrap at N.
  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + (IW+1)'(off);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any && valid[cand[IW-1:0]]) begin
        any = 1'b1;
        idx = cand[IW-1:0];
      end
    end
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Shares one GCDInner datapath between N requesters with round-robin
// arbitration and a watchdog that aborts jobs that never converge.
//   clock, reset          : rising-edge clock, synchronous active-low reset
//   req_valid/ready/a/b   : per-requester request channels (slice i*W +: W)
//   rsp_valid/ready       : response handshake
//   rsp_id/z/err          : owner, result (0 on error), watchdog abort flag
//   gcd_a/b/e             : operands and one-cycle load pulse to GCDInner
//   gcd_z/v               : GCDInner result and result-valid level
//   busy                  : scheduler not in IDLE
module gcd_rr_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*W-1:0]         req_a,
  input  logic [N*W-1:0]         req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [id_width(N)-1:0] rsp_id,
  output logic [W-1:0]           rsp_z,
  output logic                   rsp_err,
  output logic [W-1:0]           gcd_a,
  output logic [W-1:0]           gcd_b,
  output logic                   gcd_e,
  input  logic [W-1:0]           gcd_z,
  input  logic                   gcd_v,
  output logic                   busy
);

  localparam int IW  = id_width(N);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t         state, state_n;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant_idx;
  logic [N-1:0]   grant;
  logic           grant_any;
  logic [WDW-1:0] watchdog;
  logic           wd_expired;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_ready  = (state == IDLE) ? grant : '0;
  assign gcd_e      = (state == LAUNCH);
  assign busy       = (state != IDLE);
  assign wd_expired = (watchdog == WDW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_any) state_n = LAUNCH;
      LAUNCH:  state_n = WAIT;
      // gcd_v is only looked at here, so a level left over from the
      // previous job (visible during LAUNCH) can never complete this one.
      WAIT:    if (gcd_v || wd_expired) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
      gcd_a     <= '0;
      gcd_b     <= '0;
      watchdog  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (grant_any) begin
          gcd_a  <= req_a[int'(grant_idx)*W +: W];
          gcd_b  <= req_b[int'(grant_idx)*W +: W];
          rsp_id <= grant_idx;
          rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
        LAUNCH: watchdog <= '0;
        WAIT: begin
          // Result beats the watchdog when both happen in the same cycle.
          if (gcd_v) begin
            rsp_z     <= gcd_z;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (wd_expired) begin
            rsp_z     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end else if (watchdog != {WDW{1'b1}}) begin
            watchdog <= watchdog + WDW'(1);
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Self-checking bench for gcd_rr_scheduler (N=4, W=16, TIMEOUT=16).
// Contains a behavioural GCDInner (subtractive, io_v = y==0) as the shared
// datapath, and predicts grants, latency, results and aborts arithmetically.
module tb_gcd_rr_scheduler;

  localparam int N = 4;
  localparam int W = 16;
  localparam int TIMEOUT = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_z;
  logic           rsp_err;
  logic [W-1:0]   gcd_a, gcd_b, gcd_z;
  logic           gcd_e, gcd_v;
  logic           busy;

  gcd_rr_scheduler #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_err(rsp_err),
    .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_e(gcd_e), .gcd_z(gcd_z), .gcd_v(gcd_v),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural GCDInner.
  logic [W-1:0] gx = '0, gy = '0;
  always @(posedge clock) begin
    if (gcd_e) begin
      gx <= gcd_a;
      gy <= gcd_b;
    end else if (gx > gy) gx <= gx - gy;
    else gy <= gy - gx;
  end
  assign gcd_z = gx;
  assign gcd_v = (gy == '0);

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  bit rnd_ops = 0;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles of subtraction GCDInner needs before y reaches 0 (capped).
  function automatic int steps(input int a, input int b);
    int x, y, k;
    x = a; y = b; k = 0;
    while (y != 0 && k <= TIMEOUT) begin
      if (x > y) x = x - y; else y = y - x;
      k++;
    end
    return k;
  endfunction

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    repeat (cycles) @(negedge clock);
    reset = 1'b1;
    m_ptr = 0;
  endtask

  // Serve 'jobs' jobs with requesters in 'mask' held valid throughout;
  // hold = cycles rsp_ready is kept low after each response appears.
  task automatic run_jobs(input logic [N-1:0] mask, input int jobs, input int hold);
    int n, g, k, lat, cyc;
    bit ez, e_bad;
    logic [W-1:0] a, b, z;
    for (int j = 0; j < jobs; j++) begin
      rsp_ready = (hold == 0);
      req_valid = mask;
      drive_ops();
      #1;
      n = 0;
      while (req_ready == '0 && n < 40) begin @(negedge clock); #1; n++; end
      g = 0;
      for (int off = N - 1; off >= 0; off--)
        if (mask[(m_ptr + off) % N]) g = (m_ptr + off) % N;
      chk("grant", 32'(req_ready), 32'(1 << g));
      m_ptr = (g + 1) % N;
      a = opa[g]; b = opb[g];
      k = steps(int'(a), int'(b));
      ez = (k >= TIMEOUT);
      z = ez ? '0 : W'(gcd(int'(a), int'(b)));
      lat = ez ? 2 + TIMEOUT : 3 + k;
      @(negedge clock);
      if (j == jobs - 1) req_valid = '0;
      chk("launch_e", 32'(gcd_e), 32'd1);
      chk("launch_a", 32'(gcd_a), 32'(a));
      chk("launch_b", 32'(gcd_b), 32'(b));
      chk("launch_ready", 32'(req_ready), 32'd0);
      if (rnd_ops) begin
        opa[g] = W'($urandom_range(0, 31));
        opb[g] = W'($urandom_range(0, 31));
        drive_ops();
      end
      cyc = 1; e_bad = 0;
      while (!rsp_valid && cyc < TIMEOUT + 8) begin
        @(negedge clock); cyc++;
        if (gcd_e) e_bad = 1;
      end
      chk("latency", 32'(cyc), 32'(lat));
      chk("e_single", 32'(e_bad), 32'd0);
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_z", 32'(rsp_z), 32'(z));
      chk("rsp_err", 32'(rsp_err), 32'(ez));
      if (hold > 0) begin
        req_valid = '1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clock);
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_z", 32'(rsp_z), 32'(z));
          chk("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = (j == jobs - 1) ? '0 : mask;
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("post_valid", 32'(rsp_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    repeat (3) @(negedge clock);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gcd_e", 32'(gcd_e), 32'd0);
    chk("rst_gcd_a", 32'(gcd_a), 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    opa[0] = 12; opb[0] = 8;  run_jobs(4'b0001, 1, 0);
    opa[1] = 7;  opb[1] = 0;  run_jobs(4'b0010, 1, 0);
    opa[0] = 48; opb[0] = 18; run_jobs(4'b0001, 1, 10);
    opa[3] = 0;  opb[3] = 5;  run_jobs(4'b1000, 1, 0);
    opa[3] = 9;  opb[3] = 6;  run_jobs(4'b1000, 1, 0);
    // 15 steps: result lands in the timeout cycle; 16 steps: aborted.
    opa[2] = 15; opb[2] = 1;  run_jobs(4'b0100, 1, 0);
    opa[2] = 16; opb[2] = 1;  run_jobs(4'b0100, 1, 0);

    do_reset(2);
    opa[0] = 12; opb[0] = 8; opa[2] = 21; opb[2] = 14; opa[3] = 10; opb[3] = 25;
    run_jobs(4'b1101, 6, 0);

    // Reset in the middle of a long job.
    opa[0] = 65535; opb[0] = 1; drive_ops();
    req_valid = 4'b0001;
    #1;
    chk("midwait_grant", 32'(req_ready), 32'(1 << m_ptr));
    @(negedge clock);
    req_valid = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_e", 32'(gcd_e), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gcd_a", 32'(gcd_a), 32'd0);
    chk("mid_rst_gcd_b", 32'(gcd_b), 32'd0);
    reset = 1'b1;
    m_ptr = 0;
    repeat (5) @(negedge clock);
    chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
    opa[0] = 10; opb[0] = 4; opa[1] = 3; opb[1] = 3;
    opa[2] = 5;  opb[2] = 5; opa[3] = 2; opb[3] = 2;
    run_jobs(4'b1111, 1, 0);

    rnd_ops = 1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = W'($urandom_range(0, 31));
        opb[i] = W'($urandom_range(0, 31));
      end
      run_jobs(N'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
